// File: rtl/phy_rx_pkg.sv
// rtl/phy_rx_pkg.sv - shared link-training state encodings and RX word width
package phy_rx_pkg;

   localparam int DATA_W = 32;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_ACT  = 3'd1,
      ST_SETTLE    = 3'd2,
      ST_LINK_UP   = 3'd3,
      ST_LANE_LOSS = 3'd4,
      ST_FAIL      = 3'd5
   } link_state_e;

   function automatic logic [1:0] lane_en_for(input link_state_e s);
      return (s inside {ST_WAIT_ACT, ST_SETTLE, ST_LINK_UP, ST_LANE_LOSS}) ? 2'b11 : 2'b00;
   endfunction

endpackage

// File: rtl/phy_rx_timer.sv
// rtl/phy_rx_timer.sv - clearable up-counter with terminal-count compare
module phy_rx_timer #(
   parameter int W = 5
) (
   input  logic         clk_f,
   input  logic         reset,
   input  logic         clear,
   input  logic         enable,
   input  logic [W-1:0] term,
   output logic [W-1:0] count,
   output logic         done
);

   always_ff @(posedge clk_f or posedge reset) begin
      if (reset)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (enable)
         count <= count + 1'b1;
   end

   assign done = (count == term);

endmodule

// File: rtl/phy_rx_link_ctrl.sv
// rtl/phy_rx_link_ctrl.sv - two-lane RX link training FSM with gated datapath
// Optional PHY_RX_LINK_CTRL_STATS_EN adds word_cnt/loss_cnt statistics outputs.
module phy_rx_link_ctrl
   import phy_rx_pkg::*;
#(
   parameter int SETTLE_CYC  = 4,
   parameter int TIMEOUT_CYC = 16,
   parameter int MAX_RETRY   = 3
) (
   input  logic              clk_f,
   input  logic              reset,
   input  logic              active_0,
   input  logic              active_1,
   input  logic              valid_in,
   input  logic [DATA_W-1:0] data_in,
   output logic [1:0]        lane_en,
   output logic              link_up,
   output logic              valid_out,
   output logic [DATA_W-1:0] data_out,
   output logic [2:0]        state,
   output logic [1:0]        retry_cnt,
`ifdef PHY_RX_LINK_CTRL_STATS_EN
   output logic [15:0]       word_cnt,
   output logic [7:0]        loss_cnt,
`endif
   output logic              link_fail
);

   localparam int TW = $clog2((TIMEOUT_CYC > SETTLE_CYC) ? TIMEOUT_CYC : SETTLE_CYC) + 1;

   link_state_e   state_q, state_d;
   logic          tmr_clear, tmr_en, tmr_done;
   logic [TW-1:0] tmr_count, tmr_term;
   logic          both_active;
   logic          enter_loss;

   assign both_active = active_0 & active_1;
   assign state       = state_q;
   assign enter_loss  = (state_d == ST_LANE_LOSS) && (state_q != ST_LANE_LOSS);
   assign tmr_term    = (state_q == ST_SETTLE) ? TW'(SETTLE_CYC - 1) : TW'(TIMEOUT_CYC - 1);

   phy_rx_timer #(.W(TW)) u_timer (
      .clk_f  (clk_f),
      .reset  (reset),
      .clear  (tmr_clear),
      .enable (tmr_en),
      .term   (tmr_term),
      .count  (tmr_count),
      .done   (tmr_done)
   );

   // Both-active is tested before the timeout so a late lock still wins.
   always_comb begin
      state_d   = state_q;
      tmr_clear = 1'b0;
      tmr_en    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            state_d   = ST_WAIT_ACT;
            tmr_clear = 1'b1;
         end
         ST_WAIT_ACT: begin
            if (both_active) begin
               state_d   = ST_SETTLE;
               tmr_clear = 1'b1;
            end else if (tmr_done) begin
               state_d   = ST_LANE_LOSS;
               tmr_clear = 1'b1;
            end else begin
               tmr_en = 1'b1;
            end
         end
         ST_SETTLE: begin
            if (!both_active) begin
               state_d   = ST_WAIT_ACT;
               tmr_clear = 1'b1;
            end else if (tmr_done) begin
               state_d   = ST_LINK_UP;
               tmr_clear = 1'b1;
            end else begin
               tmr_en = 1'b1;
            end
         end
         ST_LINK_UP: begin
            if (!both_active)
               state_d = ST_LANE_LOSS;
         end
         ST_LANE_LOSS: begin
            state_d = (retry_cnt == 2'(MAX_RETRY)) ? ST_FAIL : ST_IDLE;
         end
         ST_FAIL: begin
            state_d = ST_FAIL;
         end
         default: begin
            state_d   = ST_IDLE;
            tmr_clear = 1'b1;
         end
      endcase
   end

   // Outputs are registered from the next state so they change on the same edge as state.
   always_ff @(posedge clk_f or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         lane_en   <= 2'b00;
         link_up   <= 1'b0;
         link_fail <= 1'b0;
         valid_out <= 1'b0;
         data_out  <= '0;
         retry_cnt <= 2'd0;
      end else begin
         state_q   <= state_d;
         lane_en   <= lane_en_for(state_d);
         link_up   <= (state_d == ST_LINK_UP);
         link_fail <= (state_d == ST_FAIL);
         if (state_d == ST_LINK_UP) begin
            valid_out <= valid_in;
            data_out  <= data_in;
         end else begin
            valid_out <= 1'b0;
            data_out  <= '0;
         end
         if ((state_d == ST_LINK_UP) && (state_q != ST_LINK_UP))
            retry_cnt <= 2'd0;
         else if (enter_loss && (retry_cnt != 2'(MAX_RETRY)))
            retry_cnt <= retry_cnt + 2'd1;
      end
   end

`ifdef PHY_RX_LINK_CTRL_STATS_EN
   always_ff @(posedge clk_f or posedge reset) begin
      if (reset) begin
         word_cnt <= 16'd0;
         loss_cnt <= 8'd0;
      end else begin
         if ((state_d == ST_LINK_UP) && valid_in)
            word_cnt <= word_cnt + 16'd1;
         if (enter_loss && (loss_cnt != 8'hFF))
            loss_cnt <= loss_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_phy_rx_link_ctrl.sv
// tb/tb_phy_rx_link_ctrl.sv - directed bench for phy_rx_link_ctrl
module tb_phy_rx_link_ctrl;

   logic        clk_f;
   logic        reset;
   logic        active_0;
   logic        active_1;
   logic        valid_in;
   logic [31:0] data_in;
   logic [1:0]  lane_en;
   logic        link_up;
   logic        valid_out;
   logic [31:0] data_out;
   logic [2:0]  state;
   logic [1:0]  retry_cnt;
   logic        link_fail;
`ifdef PHY_RX_LINK_CTRL_STATS_EN
   logic [15:0] word_cnt;
   logic [7:0]  loss_cnt;
`endif

   int tests = 0;
   int fails = 0;

   phy_rx_link_ctrl dut (
      .clk_f     (clk_f),
      .reset     (reset),
      .active_0  (active_0),
      .active_1  (active_1),
      .valid_in  (valid_in),
      .data_in   (data_in),
      .lane_en   (lane_en),
      .link_up   (link_up),
      .valid_out (valid_out),
      .data_out  (data_out),
      .state     (state),
      .retry_cnt (retry_cnt),
`ifdef PHY_RX_LINK_CTRL_STATS_EN
      .word_cnt  (word_cnt),
      .loss_cnt  (loss_cnt),
`endif
      .link_fail (link_fail)
   );

   initial begin
      clk_f = 1'b0;
      forever #5 clk_f = ~clk_f;
   end

   task automatic tick();
      @(posedge clk_f);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset    = 1'b1;
      active_0 = 1'b0;
      active_1 = 1'b0;
      valid_in = 1'b0;
      data_in  = 32'h0;
      repeat (2) tick();
      check("rst_state",     32'(state),     32'd0);
      check("rst_lane_en",   32'(lane_en),   32'd0);
      check("rst_link_up",   32'(link_up),   32'd0);
      check("rst_valid_out", 32'(valid_out), 32'd0);
      check("rst_data_out",  data_out,       32'h0);
      check("rst_retry",     32'(retry_cnt), 32'd0);
      check("rst_link_fail", 32'(link_fail), 32'd0);

      // basic training and forwarding
      reset = 1'b0;
      check("idle_lane_en", 32'(lane_en), 32'd0);
      active_0 = 1'b1;
      active_1 = 1'b1;
      tick();
      check("wait_state",   32'(state),   32'd1);
      check("wait_lane_en", 32'(lane_en), 32'd3);
      tick();
      check("settle_state", 32'(state), 32'd2);
      repeat (3) tick();
      check("settle3_state",   32'(state),   32'd2);
      check("settle3_link_up", 32'(link_up), 32'd0);
      tick();
      check("linkup_state", 32'(state),   32'd3);
      check("linkup_flag",  32'(link_up), 32'd1);
      valid_in = 1'b1;
      data_in  = 32'hA5A5_0001;
      tick();
      check("fwd1_valid", 32'(valid_out), 32'd1);
      check("fwd1_data",  data_out,       32'hA5A5_0001);
      data_in = 32'h1234_5678;
      tick();
      check("fwd2_data", data_out, 32'h1234_5678);

      // lane drop in LINK_UP
      active_0 = 1'b0;
      data_in  = 32'hDEAD_BEEF;
      tick();
      check("loss_state",     32'(state),     32'd4);
      check("loss_link_up",   32'(link_up),   32'd0);
      check("loss_valid_out", 32'(valid_out), 32'd0);
      check("loss_data_out",  data_out,       32'h0);
      check("loss_retry",     32'(retry_cnt), 32'd1);
      valid_in = 1'b0;
      active_0 = 1'b1;
      tick();
      check("loss_idle_state", 32'(state),     32'd0);
      check("loss_idle_lane",  32'(lane_en),   32'd0);
      check("loss_idle_retry", 32'(retry_cnt), 32'd1);
      repeat (5) tick();
      check("relink_settle", 32'(state), 32'd2);
      tick();
      check("relink_state", 32'(state),     32'd3);
      check("relink_retry", 32'(retry_cnt), 32'd0);

      // asynchronous reset mid-LINK_UP
      valid_in = 1'b1;
      data_in  = 32'hCAFE_0002;
      tick();
      check("pre_rst_valid", 32'(valid_out), 32'd1);
      #3;
      reset = 1'b1;
      #1;
      check("arst_state",     32'(state),     32'd0);
      check("arst_lane_en",   32'(lane_en),   32'd0);
      check("arst_link_up",   32'(link_up),   32'd0);
      check("arst_valid_out", 32'(valid_out), 32'd0);
      check("arst_data_out",  data_out,       32'h0);
      @(posedge clk_f);
      #1;
      reset    = 1'b0;
      valid_in = 1'b0;
      check("arst_idle_lane", 32'(lane_en), 32'd0);
      tick();
      check("arst_wait_state", 32'(state),   32'd1);
      check("arst_wait_lane",  32'(lane_en), 32'd3);

      // settle interrupted at its third cycle
      tick();
      check("intr_settle", 32'(state), 32'd2);
      repeat (2) tick();
      active_0 = 1'b0;
      tick();
      check("intr_back_wait", 32'(state), 32'd1);
      active_0 = 1'b1;
      tick();
      check("intr_resettle", 32'(state), 32'd2);
      repeat (3) tick();
      check("intr_no_link", 32'(link_up), 32'd0);
      tick();
      check("intr_link", 32'(link_up), 32'd1);

      // both-active arrives on the timeout cycle
      reset = 1'b1;
      tick();
      reset    = 1'b0;
      active_1 = 1'b0;
      tick();
      repeat (15) tick();
      check("tie_still_wait", 32'(state), 32'd1);
      active_1 = 1'b1;
      tick();
      check("tie_settle", 32'(state), 32'd2);

      // three timeouts lead to FAIL
      reset = 1'b1;
      tick();
      reset    = 1'b0;
      active_1 = 1'b0;
      for (int a = 1; a <= 3; a++) begin
         tick();
         check("to_wait", 32'(state), 32'd1);
         repeat (15) tick();
         check("to_wait_end", 32'(state), 32'd1);
         tick();
         check("to_loss", 32'(state),     32'd4);
         check("to_retry", 32'(retry_cnt), 32'(a));
         tick();
         check("to_after", 32'(state), (a < 3) ? 32'd0 : 32'd5);
      end
      check("fail_flag",  32'(link_fail), 32'd1);
      check("fail_lane",  32'(lane_en),   32'd0);
      check("fail_retry", 32'(retry_cnt), 32'd3);
      active_1 = 1'b1;
      repeat (4) tick();
      check("fail_hold_state", 32'(state),   32'd5);
      check("fail_hold_lane",  32'(lane_en), 32'd0);

`ifdef PHY_RX_LINK_CTRL_STATS_EN
      reset = 1'b1;
      tick();
      reset    = 1'b0;
      active_0 = 1'b1;
      active_1 = 1'b1;
      valid_in = 1'b0;
      check("st_rst_word", 32'(word_cnt), 32'd0);
      check("st_rst_loss", 32'(loss_cnt), 32'd0);
      repeat (6) tick();
      check("st_link", 32'(state), 32'd3);
      valid_in = 1'b1;
      repeat (5) tick();
      valid_in = 1'b0;
      tick();
      active_0 = 1'b0;
      tick();
      active_0 = 1'b1;
      tick();
      repeat (6) tick();
      active_0 = 1'b0;
      tick();
      active_0 = 1'b1;
      check("st_word5", 32'(word_cnt), 32'd5);
      check("st_loss2", 32'(loss_cnt), 32'd2);
      tick();
      repeat (6) tick();
      check("st_relink", 32'(state), 32'd3);
      dut.word_cnt = 16'hFFFF;
      valid_in = 1'b1;
      tick();
      check("st_wrap", 32'(word_cnt), 32'd0);
      valid_in = 1'b0;
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/phy_rx_link_ctrl.md
PHY_RX_LINK_CTRL -- requirements
Module: phy_rx_link_ctrl

Interface
REQ-001 The block SHALL have one clock, clk_f; reset is asynchronous and active-high, port reset.
REQ-002 Parameter SETTLE_CYC, 4, number of consecutive both-lanes-active cycles required before link-up.
REQ-003 Parameter TIMEOUT_CYC, 16, maximum cycles to wait for both lanes active per attempt.
REQ-004 Parameter MAX_RETRY, 3, number of failed attempts before permanent FAIL.
REQ-005 Ports SHALL be:
- clk_f  in  1  controller clock
- reset  in  1  async active-high reset
- active_0  in  1  lane 0 serial-to-parallel synced flag
- active_1  in  1  lane 1 serial-to-parallel synced flag
- valid_in  in  1  striped-datapath valid
- data_in  in  32  striped-datapath word
- lane_en  out  2  per-lane enable to receivers; bit i drives lane i
- link_up  out  1  link trained and data forwarded
- valid_out  out  1  gated valid
- data_out  out  32  gated word
- state  out  3  current FSM state
- retry_cnt  out  2  failed attempts so far
- link_fail  out  1  high in FAIL

Function
REQ-006 States SHALL be IDLE=0, WAIT_ACT=1, SETTLE=2, LINK_UP=3, LANE_LOSS=4, FAIL=5; all outputs registered.
REQ-007 IDLE: lane_en=2'b00, one cycle only, then WAIT_ACT.
REQ-008 lane_en SHALL be 2'b11 in WAIT_ACT, SETTLE, LINK_UP, LANE_LOSS; 2'b00 in IDLE, FAIL.
REQ-009 WAIT_ACT: timer increments each cycle; active_0&active_1 -> SETTLE, timer cleared; else timer==TIMEOUT_CYC-1 -> LANE_LOSS.
REQ-010 Both-active and timeout in the same cycle: both-active wins (-> SETTLE).
REQ-011 SETTLE: timer counts consecutive both-active cycles; either lane low -> WAIT_ACT with timer cleared (timeout budget restarts); count reaches SETTLE_CYC -> LINK_UP.
REQ-012 LINK_UP: link_up=1, retry_cnt cleared on entry; valid_out/data_out = valid_in/data_in delayed exactly one cycle.
REQ-013 Outside LINK_UP: valid_out=0, data_out=32'h0; a word sampled in the cycle a lane drops SHALL NOT be forwarded.
REQ-014 LINK_UP with active_0==0 or active_1==0 -> LANE_LOSS next cycle; link_up falls that same edge.
REQ-015 LANE_LOSS: one cycle; retry_cnt+1; if the new value equals MAX_RETRY -> FAIL, else -> IDLE.
REQ-016 FAIL: link_fail=1, lane_en=0, held until reset; inputs ignored.
REQ-017 retry_cnt SHALL saturate at MAX_RETRY, never wrap.

Reset
REQ-018 Reset asserted (any time, including mid-LINK_UP) SHALL immediately force state=IDLE, lane_en=0, link_up=0, valid_out=0, data_out=0, retry_cnt=0, link_fail=0, timer=0.
REQ-019 First edge after reset release SHALL act as IDLE (lane_en stays 0 one cycle).

Configuration
REQ-020 Macro PHY_RX_LINK_CTRL_STATS_EN SHALL add outputs word_cnt[15:0] (counts valid_out=1 beats, wraps 16'hFFFF->0) and loss_cnt[7:0] (counts LANE_LOSS entries, saturates at 8'hFF), both reset to 0.
REQ-021 Without PHY_RX_LINK_CTRL_STATS_EN those ports and counters SHALL be absent; all other behaviour is identical.

Structure
REQ-022 State encodings and the 32-bit word width SHALL live in shared package phy_rx_pkg, reused by the RX datapath bench.
REQ-023 The shared WAIT_ACT/SETTLE timer SHALL be sub-module phy_rx_timer (clear, enable, terminal-count compare).

Verification
REQ-024 Both lanes active from cycle 2 after reset -> SETTLE at cycle 3, LINK_UP after 4 active cycles, link_up=1; valid_in=1, data_in=32'hA5A5_0001 -> valid_out=1, data_out=32'hA5A5_0001 one cycle later.
REQ-025 active_1 never rises -> LANE_LOSS after 16 WAIT_ACT cycles; three attempts -> FAIL, link_fail=1, lane_en=0, retry_cnt=3.
REQ-026 In SETTLE, active_0 low at settle cycle 3 -> WAIT_ACT, settle count restarts; link_up only after 4 fresh consecutive cycles.
REQ-027 In LINK_UP, drop active_0 with valid_in=1, data_in=32'hDEAD_BEEF -> that word not forwarded, LANE_LOSS then IDLE, retry_cnt=1, relink clears retry_cnt to 0.
REQ-028 Assert reset mid-LINK_UP -> all outputs 0 asynchronously; release -> one IDLE cycle with lane_en=0, then normal training.
REQ-029 With PHY_RX_LINK_CTRL_STATS_EN, 5 forwarded beats and 2 lane losses -> word_cnt=5, loss_cnt=2; preload 16'hFFFF -> next beat gives 0.
